// File: rtl/poly_wave_gen_pkg.sv
// Shared types and constants for the polyphonic wave generator.
// Holds the FSM/mode enums and the noise LFSR definition.
package poly_wave_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VOICE,
    MIX
  } state_t;

  typedef enum logic [1:0] {
    SAW,
    SQUARE,
    TRI,
    NOISE
  } mode_t;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11
  // map to state bits 0,2,3,5; feedback enters bit 15.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(
    input logic [15:0] s
  );
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/poly_wave_gen_wave_shape.sv
// Combinational waveform shaper: maps a phase, a mode
// and the shared noise register to one signed sample.
module wave_shape
  import poly_wave_gen_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 16
) (
  input  logic [PHASE_W-1:0]       phase,
  input  mode_t                    mode,
  input  logic [15:0]              lfsr,
  output logic signed [OUT_W-1:0]  sample
);

  localparam logic [OUT_W-1:0] PEAK =
    {1'b0, {(OUT_W-1){1'b1}}};

  logic [OUT_W-1:0] t;
  logic [OUT_W-1:0] saw;
  logic [OUT_W-1:0] sq;
  logic [OUT_W-1:0] fold;
  logic [OUT_W-1:0] tri_w;
  logic [OUT_W-1:0] noise;
  logic             unused_phase;

  assign t = phase[PHASE_W-1 -: OUT_W];
  assign unused_phase = ^phase;

  // Build every shape, then pick the one for this voice.
  always_comb begin
    saw   = {~t[OUT_W-1], t[OUT_W-2:0]};
    sq    = phase[PHASE_W-1] ? (~PEAK + OUT_W'(1))
                             : PEAK;
    // Doubling slope; the middle half runs downward so
    // the wave peaks at 1/4 and bottoms out at 3/4.
    fold  = {t[OUT_W-2:0], 1'b0};
    tri_w = (t[OUT_W-1] ^ t[OUT_W-2]) ? ~fold : fold;
    noise = OUT_W'($signed(lfsr));
    sample = '0;
    unique case (mode)
      SAW:     sample = saw;
      SQUARE:  sample = sq;
      TRI:     sample = tri_w;
      NOISE:   sample = noise;
      default: sample = '0;
    endcase
  end

endmodule

// File: rtl/poly_wave_gen.sv
// Polyphonic oscillator: on each sample request it walks
// every voice, sums scaled waves and outputs a clipped mix.
module poly_wave_gen
  import poly_wave_gen_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 16,
  parameter int AMP_W      = 16,
  localparam int VIDX_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     aud_req,
  input  logic                     cfg_we,
  input  logic [VIDX_W-1:0]        cfg_voice,
  input  logic                     cfg_en,
  input  logic [1:0]               cfg_mode,
  input  logic [PHASE_W-1:0]       cfg_step,
  input  logic [AMP_W-1:0]         cfg_amp,
  input  logic                     cfg_phase_rst,
  output logic signed [OUT_W-1:0]  aud_data,
  output logic                     aud_done
);

  localparam int ACC_W =
    OUT_W + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = OUT_W + AMP_W + 1;
  localparam logic [VIDX_W-1:0] LAST =
    VIDX_W'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                   state;
  logic [VIDX_W-1:0]        idx;
  logic signed [ACC_W-1:0]  acc;
  logic [15:0]              lfsr;

  logic                     en_q    [NUM_VOICES];
  mode_t                    mode_q  [NUM_VOICES];
  logic [PHASE_W-1:0]       step_q  [NUM_VOICES];
  logic [AMP_W-1:0]         amp_q   [NUM_VOICES];
  logic [PHASE_W-1:0]       phase_q [NUM_VOICES];

  logic                     cur_en;
  mode_t                    cur_mode;
  logic [PHASE_W-1:0]       cur_phase;
  logic [AMP_W-1:0]         cur_amp;
  logic signed [OUT_W-1:0]  wave;
  logic signed [PROD_W-1:0] wave_x;
  logic signed [PROD_W-1:0] amp_x;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] scaled;
  logic signed [ACC_W-1:0]  contrib;
  logic                     busy_voice;
  logic                     noise_adv;
  logic                     cfg_ok;
  logic signed [OUT_W-1:0]  sat_v;

  assign cur_en    = en_q[idx];
  assign cur_mode  = mode_q[idx];
  assign cur_phase = phase_q[idx];
  assign cur_amp   = amp_q[idx];

  assign busy_voice = (state == VOICE) && cur_en;
  assign noise_adv  = busy_voice && (cur_mode == NOISE);
  assign cfg_ok = 32'(cfg_voice) < NUM_VOICES;

  wave_shape #(
    .PHASE_W (PHASE_W),
    .OUT_W   (OUT_W)
  ) u_shape (
    .phase  (cur_phase),
    .mode   (cur_mode),
    .lfsr   (lfsr),
    .sample (wave)
  );

  // Scale by amp/2^AMP_W with a flooring shift.
  always_comb begin
    wave_x  = PROD_W'(wave);
    amp_x   = PROD_W'({1'b0, cur_amp});
    prod    = wave_x * amp_x;
    scaled  = prod >>> AMP_W;
    contrib = '0;
    if (cur_en) begin
      contrib = ACC_W'(scaled);
    end
  end

  // Clip the wide mix to the signed output range.
  always_comb begin
    sat_v = acc[OUT_W-1:0];
    if (acc > SMAX) begin
      sat_v = SMAX[OUT_W-1:0];
    end else if (acc < SMIN) begin
      sat_v = SMIN[OUT_W-1:0];
    end
  end

  // Frame sequencer: walk the voices, then publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      acc      <= '0;
      lfsr     <= LFSR_SEED;
      aud_data <= '0;
      aud_done <= 1'b0;
    end else begin
      aud_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (aud_req) begin
            state <= VOICE;
            idx   <= '0;
            acc   <= '0;
          end
        end
        VOICE: begin
          acc <= acc + contrib;
          if (noise_adv) begin
            lfsr <= lfsr_next(lfsr);
          end
          if (idx == LAST) begin
            state <= MIX;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        MIX: begin
          aud_data <= sat_v;
          aud_done <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Voice table: config writes and phase advance; a
  // phase clear overrides an advance on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        en_q[v]    <= 1'b0;
        mode_q[v]  <= SAW;
        step_q[v]  <= '0;
        amp_q[v]   <= '0;
        phase_q[v] <= '0;
      end
    end else begin
      if (busy_voice) begin
        phase_q[idx] <= cur_phase + step_q[idx];
      end
      if (cfg_we && cfg_ok) begin
        en_q[cfg_voice]   <= cfg_en;
        mode_q[cfg_voice] <= mode_t'(cfg_mode);
        step_q[cfg_voice] <= cfg_step;
        amp_q[cfg_voice]  <= cfg_amp;
        if (cfg_phase_rst) begin
          phase_q[cfg_voice] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_poly_wave_gen.sv
// Directed bench for poly_wave_gen with constant
// expected samples worked out by hand.
module tb_poly_wave_gen;
  import poly_wave_gen_pkg::*;

  localparam int NV = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic               aud_req;
  logic               cfg_we;
  logic [1:0]         cfg_voice;
  logic               cfg_en;
  logic [1:0]         cfg_mode;
  logic [31:0]        cfg_step;
  logic [15:0]        cfg_amp;
  logic               cfg_phase_rst;
  logic signed [15:0] aud_data;
  logic               aud_done;

  int n_checks = 0;
  int n_err    = 0;

  poly_wave_gen #(
    .NUM_VOICES (NV),
    .PHASE_W    (32),
    .OUT_W      (16),
    .AMP_W      (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .aud_req       (aud_req),
    .cfg_we        (cfg_we),
    .cfg_voice     (cfg_voice),
    .cfg_en        (cfg_en),
    .cfg_mode      (cfg_mode),
    .cfg_step      (cfg_step),
    .cfg_amp       (cfg_amp),
    .cfg_phase_rst (cfg_phase_rst),
    .aud_data      (aud_data),
    .aud_done      (aud_done)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input int    got,
    input int    exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic cfg(
    input int          v,
    input logic        en,
    input logic [1:0]  m,
    input logic [31:0] st,
    input logic [15:0] a,
    input logic        pr
  );
    cfg_voice     = 2'(v);
    cfg_en        = en;
    cfg_mode      = m;
    cfg_step      = st;
    cfg_amp       = a;
    cfg_phase_rst = pr;
    cfg_we        = 1'b1;
    @(posedge clk); #1;
    cfg_we        = 1'b0;
    cfg_phase_rst = 1'b0;
  endtask

  // One frame; rv >= 0 pulses a phase clear for voice
  // rv (fields preset by caller) on its advance cycle.
  task automatic run_frame(
    input string tag,
    input int    exp,
    input int    rv
  );
    int lat;
    int data;
    aud_req = 1'b1;
    @(posedge clk); #1;
    aud_req = 1'b0;
    lat = 1;
    while (!aud_done && lat < 20) begin
      cfg_we        = (lat == rv + 1);
      cfg_phase_rst = cfg_we;
      @(posedge clk); #1;
      lat++;
    end
    cfg_we        = 1'b0;
    cfg_phase_rst = 1'b0;
    data = int'(aud_data);
    check({tag, "_lat"}, lat, NV + 2);
    check({tag, "_data"}, data, exp);
    @(posedge clk); #1;
    check({tag, "_pulse"}, int'(aud_done), 0);
    check({tag, "_hold"}, int'(aud_data), data);
  endtask

  initial begin
    int pulses;
    int first;
    int last;
    reset         = 1'b1;
    aud_req       = 1'b0;
    cfg_we        = 1'b0;
    cfg_voice     = '0;
    cfg_en        = 1'b0;
    cfg_mode      = '0;
    cfg_step      = '0;
    cfg_amp       = '0;
    cfg_phase_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_data", int'(aud_data), 0);
    check("rst_done", int'(aud_done), 0);

    // Single saw voice, quarter-cycle step, half gain.
    cfg(0, 1'b1, SAW, 32'h4000_0000, 16'h8000, 1'b1);
    run_frame("saw0", -16384, -1);
    run_frame("saw1", -8192, -1);
    run_frame("saw2", 0, -1);

    // Three-quarter step wraps through 2^32.
    cfg(0, 1'b1, SAW, 32'hC000_0000, 16'h8000, 1'b1);
    run_frame("wrap0", -16384, -1);
    run_frame("wrap1", 8192, -1);
    run_frame("wrap2", 0, -1);
    run_frame("wrap3", -8192, -1);
    run_frame("wrap4", -16384, -1);

    // Four full-scale squares clip both ways.
    for (int v = 0; v < NV; v++)
      cfg(v, 1'b1, SQUARE, 32'h8000_0000, 16'hFFFF, 1'b1);
    run_frame("sat_pos", 32767, -1);
    run_frame("sat_neg", -32768, -1);

    // Lone triangle at the four quarter points.
    cfg(0, 1'b1, TRI, 32'h4000_0000, 16'hFFFF, 1'b1);
    for (int v = 1; v < NV; v++)
      cfg(v, 1'b0, SAW, 32'h0, 16'h0, 1'b1);
    run_frame("tri0", 0, -1);
    run_frame("tri1", 32766, -1);
    run_frame("tri2", -1, -1);
    run_frame("tri3", -32768, -1);

    // Request held for 20 cycles.
    pulses = 0;
    first  = -1;
    last   = -1;
    aud_req = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 19) aud_req = 1'b0;
      if (aud_done) begin
        pulses++;
        if (first < 0) first = i;
        last = i;
      end
    end
    check("held_pulses", pulses, 4);
    check("held_first", first, 5);
    check("held_last", last, 23);

    // Phase clear collides with voice 1 advance.
    cfg(0, 1'b0, SAW, 32'h0, 16'h0, 1'b1);
    cfg(1, 1'b1, SAW, 32'h4000_0000, 16'h8000, 1'b1);
    run_frame("prst_a", -16384, -1);
    cfg_voice = 2'd1;
    run_frame("prst_b", -8192, 1);
    run_frame("prst_c", -16384, -1);

    // Reset in the middle of a frame.
    aud_req = 1'b1;
    @(posedge clk); #1;
    aud_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_data", int'(aud_data), 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (aud_done) pulses++;
    end
    check("mid_rst_done", pulses, 0);
    run_frame("post_rst", 0, -1);

    // Noise voice reads the LFSR from its seed.
    cfg(0, 1'b1, NOISE, 32'h0, 16'hFFFF, 1'b0);
    run_frame("noise0", -21279, -1);
    run_frame("noise1", 22127, -1);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/poly_wave_gen.md
POLY_WAVE_GEN -- requirements
Module: poly_wave_gen

Interface
REQ-001 SHALL provide parameter NUM_VOICES, default 4, number of independent oscillator voices (1..16).
REQ-002 SHALL provide parameter PHASE_W, default 32, phase accumulator and step width.
REQ-003 SHALL provide parameter OUT_W, default 16, signed sample width.
REQ-004 SHALL provide parameter AMP_W, default 16, unsigned gain width (gain = amp/2^AMP_W).
REQ-005 SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-006 Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- aud_req  in  1  sample request pulse.
- cfg_we  in  1  voice config write strobe.
- cfg_voice  in  VIDX_W=max(1,clog2(NUM_VOICES))  target voice.
- cfg_en  in  1  voice enable.
- cfg_mode  in  2  waveform select.
- cfg_step  in  PHASE_W  phase increment.
- cfg_amp  in  AMP_W  gain.
- cfg_phase_rst  in  1  clear target voice phase.
- aud_data  out  OUT_W  signed mixed sample.
- aud_done  out  1  one-cycle sample-valid pulse.

Function
REQ-007 FSM states: IDLE, VOICE, MIX. IDLE->VOICE on aud_req=1, voice index cleared to 0, accumulator cleared.
REQ-008 VOICE processes one voice per cycle (index 0..NUM_VOICES-1); after the last voice goes to MIX; MIX->IDLE after one cycle.
REQ-009 In MIX, aud_data SHALL load the saturated sum and aud_done SHALL pulse for exactly one cycle; aud_done is high NUM_VOICES+2 cycles after the aud_req sampling edge.
REQ-010 aud_req while not IDLE SHALL be ignored; aud_data holds its value between frames.
REQ-011 Waveform from phase p (top OUT_W bits t): mode 0 saw = t with MSB inverted (signed); mode 1 square = +(2^(OUT_W-1)-1) if p MSB=0 else -(2^(OUT_W-1)-1); mode 2 triangle = fold of saw, peak at p=1/4 and trough at 3/4 of the cycle, continuous; mode 3 noise = shared 16-bit Fibonacci LFSR (taps 16,14,13,11, seed 16'hACE1), sign-extended/truncated to OUT_W, advanced only when a mode-3 voice is processed.
REQ-012 Voice contribution = (wave * amp) arithmetic-shifted right AMP_W (floor); accumulator width OUT_W+clog2(NUM_VOICES)+1, signed, no internal overflow.
REQ-013 MIX SHALL saturate the accumulator to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-014 After a voice's contribution is computed, its phase SHALL advance by step modulo 2^PHASE_W (natural wrap).
REQ-015 Disabled voices contribute 0 and do not advance phase.
REQ-016 cfg_we writes en/mode/step/amp of cfg_voice in one cycle, any state; effective from that voice's next evaluation; cfg_voice >= NUM_VOICES ignored.
REQ-017 cfg_we with cfg_phase_rst=1 clears that voice's phase; if same cycle as that voice's phase advance, clear wins.

Reset
REQ-018 reset SHALL force IDLE, aud_data=0, aud_done=0, all phases/steps/amps=0, all voices disabled, mode 0, LFSR=16'hACE1; reset mid-frame aborts without aud_done.

Structure
REQ-019 A shared package SHALL hold the state enum, mode enum (SAW, SQUARE, TRI, NOISE), LFSR seed and taps.
REQ-020 Waveform shaping SHALL be a combinational sub-module wave_shape (phase, mode, lfsr in; signed sample out).

Verification
REQ-021 Voice0 saw, step 32'h40000000, amp 16'h8000, enabled; three aud_req -> aud_data -16384, -8192, 0, each aud_done at request+NUM_VOICES+2.
REQ-022 All 4 voices square, amp 16'hFFFF, phase 0 -> sum 131064 saturates, aud_data 32767.
REQ-023 Voice0 step 32'hC0000000, five frames -> phase wraps; sequence matches modulo-2^32 model.
REQ-024 aud_req held high 20 cycles -> one aud_done per NUM_VOICES+2 frame, no extra pulses while busy.
REQ-025 reset asserted in VOICE state -> no aud_done, aud_data 0, next aud_req yields a normal frame with voices disabled (aud_data 0).
REQ-026 cfg_phase_rst to voice1 on its advance cycle -> voice1 phase 0 next frame.
